alu_sched: RTL and testbench

Round-robin scheduler that shares one `alu` instance (ADD/SUB, `alu_pkg` types) between `NUM_REQ` requesters. It accepts one operation at a time over a valid/ready request channel, latches the operands, drives the shared ALU, and returns a registered result tagged with the requester index over a single valid/ready response channel. It sits between the execution clients and the ALU datapath.

---
 rtl/alu_sched.sv | 194 +++++++++++++++++++
 tb/tb_alu_sched.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_sched.sv
// rtl/alu_sched.sv - round-robin scheduler sharing one ADD/SUB ALU between NUM_REQ requesters
//
// Contents: alu_pkg (data width, opcodes), alu (combinational ADD/SUB), alu_sched (top).
// Optional feature macro: ALU_SCHED_OVF_EN adds the rsp_ovf port (signed overflow).
//
// alu_sched ports:
//   clk, rst_n            clock, synchronous active-low reset
//   req_valid/req_ready   per-requester request handshake (req_ready one-hot, IDLE only)
//   req_a/req_b/req_op    per-requester operands and opcode, requester i at slice i
//   rsp_valid/rsp_ready   response handshake
//   rsp_data/rsp_id       registered result and index of the issuing requester
//   rsp_ovf               signed overflow of the result (ALU_SCHED_OVF_EN only)
//   op_count              completed-operation counter, wraps at 16 bits

package alu_pkg;
  localparam int DATA_WIDTH = 32;
  typedef enum logic [1:0] {
    ALU_ADD = 2'd0,
    ALU_SUB = 2'd1
  } alu_opcode_t;
endpackage

// Shared datapath: modulo add/subtract, any other opcode yields zero.
module alu #(
  parameter int W = alu_pkg::DATA_WIDTH
) (
  input  logic [W-1:0]                           i_a,
  input  logic [W-1:0]                           i_b,
  input  logic [$bits(alu_pkg::alu_opcode_t)-1:0] i_op,
  output logic [W-1:0]                           o_result
);
  always_comb begin
    o_result = '0;
    case (i_op)
      alu_pkg::ALU_ADD: o_result = i_a + i_b;
      alu_pkg::ALU_SUB: o_result = i_a - i_b;
      default:          o_result = '0;
    endcase
  end
endmodule

module alu_sched #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                                              clk,
  input  logic                                              rst_n,
  input  logic [NUM_REQ-1:0]                                req_valid,
  output logic [NUM_REQ-1:0]                                req_ready,
  input  logic [NUM_REQ*alu_pkg::DATA_WIDTH-1:0]            req_a,
  input  logic [NUM_REQ*alu_pkg::DATA_WIDTH-1:0]            req_b,
  input  logic [NUM_REQ*$bits(alu_pkg::alu_opcode_t)-1:0]   req_op,
  output logic                                              rsp_valid,
  input  logic                                              rsp_ready,
  output logic [alu_pkg::DATA_WIDTH-1:0]                    rsp_data,
  output logic [ID_W-1:0]                                   rsp_id,
`ifdef ALU_SCHED_OVF_EN
  output logic                                              rsp_ovf,
`endif
  output logic [15:0]                                       op_count
);
  localparam int DW   = alu_pkg::DATA_WIDTH;
  localparam int OP_W = $bits(alu_pkg::alu_opcode_t);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t          r_state;
  logic [ID_W-1:0] r_rr_ptr;
  logic [DW-1:0]   r_a;
  logic [DW-1:0]   r_b;
  logic [OP_W-1:0] r_op;
  logic [ID_W-1:0] r_id;
  logic            r_rsp_valid;
  logic [DW-1:0]   r_rsp_data;
  logic [ID_W-1:0] r_rsp_id;
  logic [15:0]     r_op_count;
`ifdef ALU_SCHED_OVF_EN
  logic            r_rsp_ovf;
  logic            w_ovf;
`endif

  logic [NUM_REQ-1:0] w_grant;
  logic [ID_W-1:0]    w_sel;
  logic               w_any;
  int                 w_idx;
  logic [DW-1:0]      w_alu_result;

  // Grant the first valid requester at or after rr_ptr, wrapping around.
  // Gated by rst_n so no handshake can be seen while reset is held.
  always_comb begin
    w_grant = '0;
    w_sel   = '0;
    w_any   = 1'b0;
    w_idx   = 0;
    if (rst_n && r_state == S_IDLE) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        w_idx = (int'(r_rr_ptr) + k) % NUM_REQ;
        if (!w_any && req_valid[w_idx]) begin
          w_any          = 1'b1;
          w_sel          = ID_W'(w_idx);
          w_grant[w_idx] = 1'b1;
        end
      end
    end
  end

  assign req_ready = w_grant;

  // The ALU only ever sees the latched operands, never the request ports.
  alu #(.W(DW)) u_alu (
    .i_a      (r_a),
    .i_b      (r_b),
    .i_op     (r_op),
    .o_result (w_alu_result)
  );

`ifdef ALU_SCHED_OVF_EN
  // Signed overflow from sign bits: ADD overflows when like-signed operands
  // produce a differently signed result; SUB when unlike-signed operands
  // produce a result whose sign differs from a.
  always_comb begin
    w_ovf = 1'b0;
    case (r_op)
      alu_pkg::ALU_ADD: w_ovf = (r_a[DW-1] == r_b[DW-1]) && (w_alu_result[DW-1] != r_a[DW-1]);
      alu_pkg::ALU_SUB: w_ovf = (r_a[DW-1] != r_b[DW-1]) && (w_alu_result[DW-1] != r_a[DW-1]);
      default:          w_ovf = 1'b0;
    endcase
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_rr_ptr    <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_op        <= '0;
      r_id        <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_id    <= '0;
      r_op_count  <= '0;
`ifdef ALU_SCHED_OVF_EN
      r_rsp_ovf   <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_a      <= req_a[int'(w_sel)*DW +: DW];
            r_b      <= req_b[int'(w_sel)*DW +: DW];
            r_op     <= req_op[int'(w_sel)*OP_W +: OP_W];
            r_id     <= w_sel;
            r_rr_ptr <= (w_sel == ID_W'(NUM_REQ-1)) ? '0 : w_sel + ID_W'(1);
            r_state  <= S_EXEC;
          end
        end
        S_EXEC: begin
          r_rsp_data  <= w_alu_result;
          r_rsp_id    <= r_id;
`ifdef ALU_SCHED_OVF_EN
          r_rsp_ovf   <= w_ovf;
`endif
          r_rsp_valid <= 1'b1;
          r_state     <= S_RESP;
        end
        S_RESP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_op_count  <= r_op_count + 16'd1;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_rsp_valid <= 1'b0;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;
  assign rsp_id    = r_rsp_id;
  assign op_count  = r_op_count;
`ifdef ALU_SCHED_OVF_EN
  assign rsp_ovf   = r_rsp_ovf;
`endif

endmodule

// File: tb/tb_alu_sched.sv
// tb/tb_alu_sched.sv - self-checking bench for alu_sched (reference model plus directed vectors)
module tb_alu_sched;
  localparam int N = 4;
  localparam int W = 32;

  logic             clk;
  logic             rst_n;
  logic [N-1:0]     req_valid;
  logic [N-1:0]     req_ready;
  logic [N*W-1:0]   req_a;
  logic [N*W-1:0]   req_b;
  logic [N*2-1:0]   req_op;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [W-1:0]     rsp_data;
  logic [1:0]       rsp_id;
`ifdef ALU_SCHED_OVF_EN
  logic             rsp_ovf;
`endif
  logic [15:0]      op_count;

  int n_cmp = 0;
  int n_bad = 0;

  alu_sched #(.NUM_REQ(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_op    (req_op),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_id    (rsp_id),
`ifdef ALU_SCHED_OVF_EN
    .rsp_ovf   (rsp_ovf),
`endif
    .op_count  (op_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [W-1:0] ref_result(input int op, input logic [W-1:0] a, input logic [W-1:0] b);
    longint s;
    if (op == 0)      s = longint'(a) + longint'(b);
    else if (op == 1) s = longint'(a) - longint'(b);
    else              s = 0;
    return s[W-1:0];
  endfunction

  function automatic logic ref_ovf(input int op, input logic [W-1:0] a, input logic [W-1:0] b);
    longint sa, sb, s;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (op == 0)      s = sa + sb;
    else if (op == 1) s = sa - sb;
    else              return 1'b0;
    return (s > 64'sd2147483647) || (s < -64'sd2147483648);
  endfunction

  function automatic int pick(input logic [N-1:0] v, input int ptr);
    for (int k = 0; k < N; k++)
      if (v[(ptr + k) % N]) return (ptr + k) % N;
    return -1;
  endfunction

  // Model phases: 0 waiting for a grant, 1 operation in ALU, 2 response offered.
  int          m_phase = 0;
  int          m_ptr   = 0;
  int          m_id    = 0;
  int          m_op    = 0;
  logic [W-1:0] m_a    = '0;
  logic [W-1:0] m_b    = '0;
  logic [W-1:0] m_data = '0;
  logic         m_ovf  = 1'b0;
  int           m_rid  = 0;
  logic [15:0]  m_cnt  = '0;
  bit           m_seen = 1'b0;

  always @(negedge clk) begin
    int g;
    logic [N-1:0] exp_ready;
    exp_ready = '0;
    g = (rst_n && m_phase == 0) ? pick(req_valid, m_ptr) : -1;
    if (g >= 0) exp_ready[g] = 1'b1;
    chk("m_req_ready", 64'(req_ready), 64'(exp_ready));
    chk("m_rsp_valid", 64'(rsp_valid), 64'(m_phase == 2));
    chk("m_op_count",  64'(op_count),  64'(m_cnt));
    if (m_phase == 2 || !m_seen) begin
      chk("m_rsp_data", 64'(rsp_data), 64'(m_data));
      chk("m_rsp_id",   64'(rsp_id),   64'(m_rid));
`ifdef ALU_SCHED_OVF_EN
      chk("m_rsp_ovf",  64'(rsp_ovf),  64'(m_ovf));
`endif
    end
    // advance to the state after the coming rising edge
    if (!rst_n) begin
      m_phase = 0; m_ptr = 0; m_cnt = '0; m_seen = 1'b0;
      m_data = '0; m_rid = 0; m_ovf = 1'b0;
    end else if (m_phase == 0) begin
      if (g >= 0) begin
        m_id = g; m_a = req_a[g*W +: W]; m_b = req_b[g*W +: W]; m_op = int'(req_op[g*2 +: 2]);
        m_ptr = (g + 1) % N;
        m_phase = 1;
      end
    end else if (m_phase == 1) begin
      m_data = ref_result(m_op, m_a, m_b);
      m_ovf  = ref_ovf(m_op, m_a, m_b);
      m_rid  = m_id;
      m_seen = 1'b1;
      m_phase = 2;
    end else if (rsp_ready) begin
      m_cnt = m_cnt + 16'd1;
      m_phase = 0;
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic step;
    @(posedge clk); #1;
  endtask

  task automatic sample;
    @(negedge clk);
  endtask

  task automatic set_req(input int i, input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] op);
    req_a[i*W +: W] = a;
    req_b[i*W +: W] = b;
    req_op[i*2 +: 2] = op;
  endtask

  typedef struct {
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] res;
    logic         ovf;
  } vec_t;

  vec_t vecs[5];
  int   g_id[8];
  int   g_cyc[8];
  int   n_g;

  initial begin
    vecs[0] = '{2'd0, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 1'b1};
    vecs[1] = '{2'd0, 32'hFFFF_FFFF, 32'h1, 32'h0,         1'b0};
    vecs[2] = '{2'd1, 32'h0,         32'h1, 32'hFFFF_FFFF, 1'b0};
    vecs[3] = '{2'd1, 32'h8000_0000, 32'h1, 32'h7FFF_FFFF, 1'b1};
    vecs[4] = '{2'd3, 32'h9,         32'h9, 32'h0,         1'b0};

    rst_n = 1'b0; req_valid = '0; req_a = '0; req_b = '0; req_op = '0; rsp_ready = 1'b1;
    step; step;
    sample;
    chk("rst_req_ready", 64'(req_ready), 64'h0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'h0);
    chk("rst_rsp_data",  64'(rsp_data),  64'h0);
    chk("rst_rsp_id",    64'(rsp_id),    64'h0);
    chk("rst_op_count",  64'(op_count),  64'h0);

    // single op: requester 2, ADD 5+7
    step; rst_n = 1'b1;
    step; set_req(2, 32'd5, 32'd7, 2'd0); req_valid = 4'b0100;
    sample; chk("single_ready", 64'(req_ready), 64'b0100);
    step; req_valid = '0;
    sample; chk("single_exec_valid", 64'(rsp_valid), 64'h0);
    step;
    sample;
    chk("single_valid", 64'(rsp_valid), 64'h1);
    chk("single_data",  64'(rsp_data),  64'd12);
    chk("single_id",    64'(rsp_id),    64'd2);
    step;
    sample; chk("single_count", 64'(op_count), 64'd1);

    // round robin from a fresh reset, all requesters hold SUB
    step; rst_n = 1'b0;
    step; rst_n = 1'b1;
    for (int i = 0; i < N; i++) set_req(i, 32'(100 + 10 * i), 32'(i), 2'd1);
    req_valid = 4'b1111;
    n_g = 0;
    for (int c = 0; c < 15; c++) begin
      sample;
      if (req_ready != '0 && n_g < 8) begin
        for (int i = 0; i < N; i++) if (req_ready[i]) g_id[n_g] = i;
        g_cyc[n_g] = c;
        n_g++;
      end
      step;
    end
    req_valid = '0;
    chk("rr_grants", 64'(n_g), 64'd5);
    for (int g = 0; g < 5 && g < n_g; g++) begin
      chk("rr_order", 64'(g_id[g]), 64'(g % N));
      if (g > 0) chk("rr_spacing", 64'(g_cyc[g] - g_cyc[g-1]), 64'd3);
    end
    repeat (3) step;

    // back-pressure: requester 1 SUB 3-5 held; requester 3 waits meanwhile
    rsp_ready = 1'b0;
    set_req(1, 32'd3, 32'd5, 2'd1);
    set_req(3, 32'd1, 32'd1, 2'd0);
    req_valid = 4'b0010;
    sample; chk("bp_ready", 64'(req_ready), 64'b0010);
    step; req_valid = 4'b1000;
    step;
    for (int k = 0; k < 10; k++) begin
      if (k == 9) rsp_ready = 1'b1;
      sample;
      chk("bp_valid", 64'(rsp_valid), 64'h1);
      chk("bp_data",  64'(rsp_data),  64'hFFFF_FFFE);
      chk("bp_id",    64'(rsp_id),    64'd1);
      chk("bp_noready", 64'(req_ready), 64'h0);
      step;
    end
    sample;
    chk("bp_release_ready", 64'(req_ready), 64'b1000);
    chk("bp_count", 64'(op_count), 64'd6);
    step; req_valid = '0;
    step;
    sample;
    chk("bp_next_data", 64'(rsp_data), 64'd2);
    chk("bp_next_id",   64'(rsp_id),   64'd3);
    step;

    // wrap, overflow and unknown-opcode vectors, one per requester in turn
    for (int v = 0; v < 5; v++) begin
      set_req(v % N, vecs[v].a, vecs[v].b, vecs[v].op);
      req_valid = '0;
      req_valid[v % N] = 1'b1;
      sample; chk("vec_ready", 64'(req_ready), 64'(1 << (v % N)));
      step; req_valid = '0;
      step;
      sample;
      chk("vec_data", 64'(rsp_data), 64'(vecs[v].res));
`ifdef ALU_SCHED_OVF_EN
      chk("vec_ovf",  64'(rsp_ovf),  64'(vecs[v].ovf));
`endif
      step;
    end

    // reset one cycle after acceptance drops the operation
    set_req(2, 32'd1, 32'd2, 2'd0);
    req_valid = 4'b0100;
    sample;
    step; req_valid = '0; rst_n = 1'b0;
    step; rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      sample;
      chk("mid_rst_valid", 64'(rsp_valid), 64'h0);
      chk("mid_rst_count", 64'(op_count),  64'h0);
      step;
    end
    req_valid = 4'b1111;
    sample; chk("mid_rst_grant", 64'(req_ready), 64'b0001);
    step; req_valid = '0;
    repeat (3) step;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
